// File: rtl/fir_sequencer_if.sv
// rtl/fir_sequencer_if.sv - Host/datapath-facing signal bundle of the FIR sequencer
interface fir_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              dr;
    logic              lc;
    logic [1:0]        coeff_num;
    logic              overflow;
    logic              cnt_up;
    logic              modwait;
    logic [2:0]        op;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [ADDR_W-1:0] dest;
    logic              err;

    // master: host, coefficient loader and ALU side; slave: the sequencer
    modport master (
        output dr, lc, coeff_num, overflow,
        input  cnt_up, modwait, op, src1, src2, dest, err
    );

    modport slave (
        input  dr, lc, coeff_num, overflow,
        output cnt_up, modwait, op, src1, src2, dest, err
    );
endinterface

// File: rtl/fir_sequencer.sv
// rtl/fir_sequencer.sv - 4-tap FIR sample/MAC and coefficient-load sequencer
// Optional overflow abort to EIDLE compiled in by FIR_SEQ_OVERFLOW_ERR_EN.
module fir_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    fir_sequencer_if.slave   bus
);
    typedef enum logic [4:0] {
        S_IDLE, S_EIDLE, S_STORE, S_SH3, S_SH2, S_SH1, S_NEW, S_ZERO,
        S_MUL1, S_ADD1, S_MUL2, S_SUB2, S_MUL3, S_ADD3, S_MUL4, S_SUB4,
        S_LOADC
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LOAD1 = 3'b010;
    localparam logic [2:0] OP_LOAD2 = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    localparam logic [ADDR_W-1:0] R0  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] R1  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] R2  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] R3  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] R4  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] R5  = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] R6  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] R7  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] R8  = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] R9  = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] R10 = ADDR_W'(10);

    state_t            state, next_state;
    logic              modwait_q, err_q;
    logic              ovf_abort;
    logic [2:0]        op_d;
    logic [ADDR_W-1:0] src1_d, src2_d, dest_d;
    logic              cnt_up_d;

`ifdef FIR_SEQ_OVERFLOW_ERR_EN
    assign ovf_abort = bus.overflow;
`else
    logic unused_overflow;
    assign unused_overflow = bus.overflow;
    assign ovf_abort       = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= S_IDLE;
            modwait_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= next_state;
            modwait_q <= (next_state != S_IDLE) && (next_state != S_EIDLE);
            err_q     <= (next_state == S_EIDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_EIDLE: begin
                if (bus.dr)      next_state = S_STORE;
                else if (bus.lc) next_state = S_LOADC;
            end
            // A sample whose dr falls before it is latched is dropped as an error
            S_STORE: next_state = bus.dr ? S_SH3 : S_EIDLE;
            S_SH3:   next_state = S_SH2;
            S_SH2:   next_state = S_SH1;
            S_SH1:   next_state = S_NEW;
            S_NEW:   next_state = S_ZERO;
            S_ZERO:  next_state = S_MUL1;
            S_MUL1:  next_state = S_ADD1;
            S_ADD1:  next_state = ovf_abort ? S_EIDLE : S_MUL2;
            S_MUL2:  next_state = S_SUB2;
            S_SUB2:  next_state = ovf_abort ? S_EIDLE : S_MUL3;
            S_MUL3:  next_state = S_ADD3;
            S_ADD3:  next_state = ovf_abort ? S_EIDLE : S_MUL4;
            S_MUL4:  next_state = S_SUB4;
            S_SUB4:  next_state = ovf_abort ? S_EIDLE : S_IDLE;
            S_LOADC: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        op_d     = OP_NOP;
        src1_d   = R0;
        src2_d   = R0;
        dest_d   = R0;
        cnt_up_d = 1'b0;
        case (state)
            S_STORE: begin op_d = OP_LOAD1; dest_d = R10; cnt_up_d = 1'b1; end
            S_SH3:   begin op_d = OP_COPY; src1_d = R3;  dest_d = R4; end
            S_SH2:   begin op_d = OP_COPY; src1_d = R2;  dest_d = R3; end
            S_SH1:   begin op_d = OP_COPY; src1_d = R1;  dest_d = R2; end
            S_NEW:   begin op_d = OP_COPY; src1_d = R10; dest_d = R1; end
            S_ZERO:  begin op_d = OP_SUB; end
            S_MUL1:  begin op_d = OP_MUL; src1_d = R1; src2_d = R5; dest_d = R9; end
            S_ADD1:  begin op_d = OP_ADD; src2_d = R9; end
            S_MUL2:  begin op_d = OP_MUL; src1_d = R2; src2_d = R6; dest_d = R9; end
            S_SUB2:  begin op_d = OP_SUB; src2_d = R9; end
            S_MUL3:  begin op_d = OP_MUL; src1_d = R3; src2_d = R7; dest_d = R9; end
            S_ADD3:  begin op_d = OP_ADD; src2_d = R9; end
            S_MUL4:  begin op_d = OP_MUL; src1_d = R4; src2_d = R8; dest_d = R9; end
            S_SUB4:  begin op_d = OP_SUB; src2_d = R9; end
            S_LOADC: begin op_d = OP_LOAD2; dest_d = R5 + ADDR_W'(bus.coeff_num); end
            default: ;
        endcase
    end

    assign bus.op      = op_d;
    assign bus.src1    = src1_d;
    assign bus.src2    = src2_d;
    assign bus.dest    = dest_d;
    assign bus.cnt_up  = cnt_up_d;
    assign bus.modwait = modwait_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_fir_sequencer.sv
// tb/tb_fir_sequencer.sv - Directed self-checking bench for fir_sequencer
module tb_fir_sequencer;
    logic tb_clk;
    logic n_reset;
    int   checks = 0;
    int   errors = 0;

    int exp_op [14] = '{2, 1, 1, 1, 1, 5, 6, 4, 6, 5, 6, 4, 6, 5};
    int exp_s1 [14] = '{0, 3, 2, 1, 10, 0, 1, 0, 2, 0, 3, 0, 4, 0};
    int exp_s2 [14] = '{0, 0, 0, 0, 0, 0, 5, 9, 6, 9, 7, 9, 8, 9};
    int exp_d  [14] = '{10, 4, 3, 2, 1, 0, 9, 0, 9, 0, 9, 0, 9, 0};

    fir_sequencer_if #(.ADDR_W(4)) bus ();

    fir_sequencer #(.ADDR_W(4)) dut (
        .clk     (tb_clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int op, input int s1, input int s2,
                                input int d, input int cnt, input int mw, input int er);
        check($sformatf("%s_op", tag),      {29'd0, bus.op},      op);
        check($sformatf("%s_src1", tag),    {28'd0, bus.src1},    s1);
        check($sformatf("%s_src2", tag),    {28'd0, bus.src2},    s2);
        check($sformatf("%s_dest", tag),    {28'd0, bus.dest},    d);
        check($sformatf("%s_cnt_up", tag),  {31'd0, bus.cnt_up},  cnt);
        check($sformatf("%s_modwait", tag), {31'd0, bus.modwait}, mw);
        check($sformatf("%s_err", tag),     {31'd0, bus.err},     er);
    endtask

    task automatic expect_idle(input string tag, input int er);
        expect_state(tag, 0, 0, 0, 0, 0, 0, er);
    endtask

    // Each index is entered by one clock step; dr is released once STORE has been left
    task automatic walk(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step();
            if (i == 1) bus.dr = 1'b0;
            expect_state($sformatf("%s_s%0d", tag, i), exp_op[i], exp_s1[i], exp_s2[i],
                         exp_d[i], (i == 0) ? 1 : 0, 1, 0);
        end
    endtask

    initial begin
        bus.dr        = 1'b0;
        bus.lc        = 1'b0;
        bus.coeff_num = 2'd0;
        bus.overflow  = 1'b0;
        n_reset       = 1'b1;
        #1 n_reset = 1'b0;
        #1 expect_idle("reset_async", 0);
        repeat (2) step();
        expect_idle("reset_held", 0);
        n_reset = 1'b1;
        step();
        expect_idle("reset_release", 0);

        // Single sample, full MAC sequence
        bus.dr = 1'b1;
        walk("seq", 0, 13);
        step();
        expect_idle("seq_end", 0);
        step();
        expect_idle("seq_stay", 0);

        // Coefficient loads
        for (int k = 0; k < 4; k++) begin
            bus.lc        = 1'b1;
            bus.coeff_num = 2'(k);
            step();
            bus.lc = 1'b0;
            expect_state($sformatf("loadc%0d", k), 3, 0, 0, 5 + k, 0, 1, 0);
            step();
            expect_idle($sformatf("loadc%0d_end", k), 0);
        end

        // dr and lc together: sample first, load deferred to IDLE
        bus.dr        = 1'b1;
        bus.lc        = 1'b1;
        bus.coeff_num = 2'd2;
        walk("both", 0, 13);
        step();
        expect_idle("both_idle", 0);
        step();
        bus.lc = 1'b0;
        expect_state("both_loadc", 3, 0, 0, 7, 0, 1, 0);
        step();
        expect_idle("both_loadc_end", 0);

        // dr dropped in STORE
        bus.dr = 1'b1;
        step();
        bus.dr = 1'b0;
        expect_state("drop_store", 2, 0, 0, 10, 1, 1, 0);
        step();
        expect_idle("drop_eidle", 1);
        step();
        expect_idle("drop_eidle_hold", 1);
        bus.dr = 1'b1;
        walk("recover", 0, 13);
        step();
        expect_idle("recover_end", 0);

        // Reset asserted in MUL2
        bus.dr = 1'b1;
        walk("mid", 0, 8);
        #2 n_reset = 1'b0;
        #1 expect_idle("mid_reset_async", 0);
        #2 n_reset = 1'b1;
        step();
        expect_idle("mid_after", 0);
        step();
        expect_idle("mid_after2", 0);

        // Overflow during SUB2
        bus.dr = 1'b1;
        walk("ovf", 0, 9);
        bus.overflow = 1'b1;
        step();
        bus.overflow = 1'b0;
`ifdef FIR_SEQ_OVERFLOW_ERR_EN
        expect_idle("ovf_eidle", 1);
        step();
        expect_idle("ovf_no_mul3", 1);
        bus.dr = 1'b1;
        walk("ovf_recover", 0, 13);
        step();
        expect_idle("ovf_recover_end", 0);
`else
        expect_state("ovf_mul3", 6, 3, 7, 9, 0, 1, 0);
        walk("ovf_cont", 11, 13);
        step();
        expect_idle("ovf_end", 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Main sequencing controller for the 4-tap FIR filter datapath. It stores each incoming sample into the shared register file/ALU, shifts the sample history, and runs the multiply-accumulate sequence. It also arbitrates the same datapath for coefficient loads requested by the coefficient loader. `modwait` is the single busy indication back to the host side and to the coefficient loader.

## Interface
Parameters:
- ADDR_W, default 4: register-file address width; must be ≥4.

Ports:
- clk  in  1  system clock, rising-edge
- n_reset  in  1  reset; one clock, asynchronous, active-low
- dr  in  1  data ready: new sample present on datapath input
- lc  in  1  load coefficient request (from coefficient loader `load_coeff`)
- coeff_num  in  2  coefficient index for the load (from coefficient loader)
- overflow  in  1  ALU overflow flag, combinational, valid in the same cycle as op
- cnt_up  out  1  one-cycle pulse per accepted sample
- modwait  out  1  busy; registered
- op  out  3  ALU op: NOP=000, COPY=001, LOAD1=010 (sample), LOAD2=011 (coeff), ADD=100, SUB=101, MUL=110
- src1, src2, dest  out  ADDR_W  register-file addresses
- err  out  1  error flag; registered

## Operation
Register map:
- R0: result/accumulator
- R1–R4: samples, R1 newest
- R5–R8: coefficients F0–F3
- R9: product temp
- R10: sample staging

States, with the op and register fields driven in each:
- IDLE / EIDLE: op=NOP.
- STORE: LOAD1 dest=R10; cnt_up=1.
- SH3: COPY R4←R3.
- SH2: COPY R3←R2.
- SH1: COPY R2←R1.
- NEW: COPY R1←R10.
- ZERO: SUB R0←R0−R0.
- MUL1: R9←R1*R5.
- ADD1: R0←R0+R9.
- MUL2: R9←R2*R6.
- SUB2: R0←R0−R9.
- MUL3: R9←R3*R7.
- ADD3: R0←R0+R9.
- MUL4: R9←R4*R8.
- SUB4: R0←R0−R9.
- LOADC: LOAD2 dest=5+coeff_num.
- Unused address fields are driven to 0.

Transitions:
- IDLE: dr=1 → STORE; else lc=1 → LOADC; else stay. dr has priority over lc when both are high.
- STORE: dr=0 in this cycle → EIDLE (sample dropped); else → SH3.
- Each of SH3 through SUB4 advances to the next state unconditionally.
- SUB4 → IDLE.
- Overflow in ADD1, SUB2, ADD3 or SUB4 → EIDLE.
- LOADC → IDLE; it lasts exactly 1 cycle.
- EIDLE: dr=1 → STORE; lc=1 → LOADC; else stay.
- lc asserted during a sample sequence is not serviced until the next IDLE/EIDLE.
- coeff_num is sampled only in LOADC.

Outputs:
- modwait = registered (next_state ∉ {IDLE, EIDLE}).
- err = registered (next_state == EIDLE). It clears when EIDLE is left.

## Timing
- Reset: state=IDLE, modwait=0, err=0, cnt_up=0, op=000, src1/src2/dest=0.
- Reset asserted mid-sequence aborts immediately. R0 contents are not guaranteed.
- op, src and dest are Moore outputs decoded from the current state. cnt_up is also decoded from state.
- dr high at edge k → STORE during cycle k+1, with modwait=1 from edge k.
- Full sample sequence is 14 cycles (STORE..SUB4). modwait falls at the edge entering IDLE. Result is valid in R0 at that point.
- Back-to-back: dr high again in the IDLE cycle → next STORE one cycle later; minimum period 15 cycles.
- Coefficient load: lc at edge k → LOADC during cycle k+1 with modwait=1 → IDLE with modwait=0 at k+2.
- Overflow in state S at edge k → EIDLE at k+1, with err=1 and modwait=0 from edge k. Remaining MAC states are skipped.

## Configuration
- FIR_SEQ_OVERFLOW_ERR_EN defined: the overflow→EIDLE transitions are compiled in, as above.
- FIR_SEQ_OVERFLOW_ERR_EN undefined: the overflow input is ignored and the sequence always completes to IDLE. err is raised only by the dr drop in STORE.

## Test plan
- Reset mid-sequence (assert n_reset in MUL2): all outputs 0 asynchronously; state IDLE after release; no cnt_up.
- Single sample, overflow=0: dr one edge → cnt_up=1 for 1 cycle. Then op sequence 010,001,001,001,001,101,110,100,110,101,110,100,110,101 with dest 10,4,3,2,1,0,9,0,9,0,9,0,9,0. modwait high for exactly 14 cycles.
- Coefficient loads: lc with coeff_num=0..3 → op=011, dest=5,6,7,8 for 1 cycle each, modwait 1 cycle. dr and lc together → STORE taken, LOADC taken after SUB4.
- dr dropped in STORE → EIDLE, err=1, modwait=0. Next dr → STORE with err cleared at that edge.
- Overflow=1 in SUB2 (macro defined) → EIDLE next cycle, err=1, no MUL3. Same stimulus with macro undefined → full 14-cycle sequence, err=0.
